sirv_axi_sram_slv: RTL and testbench

SIRV_AXI_SRAM_SLV -- requirements
Module: sirv_axi_sram_slv

---
 rtl/sirv_axi_sram_slv.sv | 129 ++++++++++++
 tb/tb_sirv_axi_sram_slv.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_axi_sram_slv.sv
// sirv_axi_sram_slv: AXI slave on a DEPTH x DW synchronous SRAM, one transaction at a time.
// Define SIRV_AXI_SRAM_RANGE_CHK_EN to answer DECERR for start addresses beyond DEPTH words.
module sirv_axi_sram_slv #(
   parameter int AW    = 32,
   parameter int DW    = 64,
   parameter int DEPTH = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            axi_arvalid,
   output logic            axi_arready,
   input  logic [AW-1:0]   axi_araddr,
   input  logic [3:0]      axi_arcache,
   input  logic [2:0]      axi_arprot,
   input  logic [1:0]      axi_arlock,
   input  logic [1:0]      axi_arburst,
   input  logic [3:0]      axi_arlen,
   input  logic [2:0]      axi_arsize,
   input  logic            axi_awvalid,
   output logic            axi_awready,
   input  logic [AW-1:0]   axi_awaddr,
   input  logic [3:0]      axi_awcache,
   input  logic [2:0]      axi_awprot,
   input  logic [1:0]      axi_awlock,
   input  logic [1:0]      axi_awburst,
   input  logic [3:0]      axi_awlen,
   input  logic [2:0]      axi_awsize,
   output logic            axi_rvalid,
   input  logic            axi_rready,
   output logic [DW-1:0]   axi_rdata,
   output logic [1:0]      axi_rresp,
   output logic            axi_rlast,
   input  logic            axi_wvalid,
   output logic            axi_wready,
   input  logic [DW-1:0]   axi_wdata,
   input  logic [DW/8-1:0] axi_wstrb,
   input  logic            axi_wlast,
   output logic            axi_bvalid,
   input  logic            axi_bready,
   output logic [1:0]      axi_bresp
);
   localparam int IW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;
   state_t state, nxt;
   logic [DW-1:0] mem [DEPTH];
   logic [IW-1:0] idx, nxt_idx, ar_idx, aw_idx;
   logic [3:0] len, cnt, cnt_inc;
   logic [1:0] burst;
   logic oor, ar_oor, aw_oor;
   logic ar_hs, aw_hs, r_hs, w_hs;
   logic unused;
   assign axi_arready = (state == IDLE) && !rst;
   assign axi_awready = (state == IDLE) && !rst && !axi_arvalid;
   assign axi_rvalid  = (state == RD);
   assign axi_wready  = (state == WR);
   assign axi_bvalid  = (state == WRESP);
   assign ar_hs = axi_arvalid && axi_arready;
   assign aw_hs = axi_awvalid && axi_awready;
   assign r_hs  = axi_rvalid && axi_rready;
   assign w_hs  = axi_wvalid && axi_wready;
   assign ar_idx = axi_araddr[3+IW-1:3];
   assign aw_idx = axi_awaddr[3+IW-1:3];
   assign nxt_idx = (burst == 2'b00) ? idx : idx + 1'b1;
   assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
`ifdef SIRV_AXI_SRAM_RANGE_CHK_EN
   assign ar_oor = |axi_araddr[AW-1:3+IW];
   assign aw_oor = |axi_awaddr[AW-1:3+IW];
`else
   assign ar_oor = 1'b0;
   assign aw_oor = 1'b0;
`endif
   assign unused = ^{axi_arcache, axi_arprot, axi_arlock, axi_arsize, axi_araddr,
                     axi_awcache, axi_awprot, axi_awlock, axi_awsize, axi_awaddr};
   always_ff @(posedge clk)
      state <= rst ? IDLE : nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = ar_hs ? RD : aw_hs ? WR : IDLE;
         RD:      nxt = (r_hs && axi_rlast) ? IDLE : RD;
         WR:      nxt = (w_hs && axi_wlast) ? WRESP : WR;
         WRESP:   nxt = axi_bready ? IDLE : WRESP;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         len       <= '0;
         cnt       <= '0;
         burst     <= '0;
         oor       <= 1'b0;
         axi_rdata <= '0;
         axi_rresp <= 2'b00;
         axi_rlast <= 1'b0;
         axi_bresp <= 2'b00;
      end else begin
         if (ar_hs || aw_hs) begin
            idx   <= ar_hs ? ar_idx : aw_idx;
            len   <= ar_hs ? axi_arlen : axi_awlen;
            burst <= ar_hs ? axi_arburst : axi_awburst;
            oor   <= ar_hs ? ar_oor : aw_oor;
            cnt   <= '0;
         end
         if (ar_hs) begin
            axi_rdata <= ar_oor ? '0 : mem[ar_idx];
            axi_rresp <= ar_oor ? 2'b11 : (axi_arburst == 2'b11) ? 2'b10 : 2'b00;
            axi_rlast <= (axi_arlen == 4'd0);
         end
         // The next beat is fetched on the handshake so it is valid the following cycle.
         if (r_hs) begin
            idx       <= nxt_idx;
            cnt       <= cnt_inc;
            axi_rdata <= oor ? '0 : mem[nxt_idx];
            axi_rlast <= (cnt_inc == len);
         end
         if (w_hs) begin
            idx <= nxt_idx;
            cnt <= cnt_inc;
            if (axi_wlast)
               axi_bresp <= oor ? 2'b11 : (burst == 2'b11 || cnt != len) ? 2'b10 : 2'b00;
         end
      end
   end
   always_ff @(posedge clk)
      if (!rst && w_hs && !oor && burst != 2'b11)
         for (int b = 0; b < DW/8; b++)
            if (axi_wstrb[b]) mem[idx][8*b +: 8] <= axi_wdata[8*b +: 8];
endmodule

// File: tb/tb_sirv_axi_sram_slv.sv
// tb_sirv_axi_sram_slv: randomized bench with a word-array model of the SRAM.
module tb_sirv_axi_sram_slv;
   logic clk = 0, rst = 1;
   logic arvalid = 0, arready, awvalid = 0, awready;
   logic [31:0] araddr = 0, awaddr = 0;
   logic [3:0] arcache = 0, awcache = 0, arlen = 0, awlen = 0;
   logic [2:0] arprot = 0, awprot = 0, arsize = 3, awsize = 3;
   logic [1:0] arlock = 0, awlock = 0, arburst = 0, awburst = 0;
   logic rvalid, rready = 0, rlast, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
   logic [63:0] rdata, wdata = 0;
   logic [1:0] rresp, bresp;
   logic [7:0] wstrb = 0;
   logic [63:0] mem_m [256];
   logic [63:0] wd [16];
   logic [7:0]  ws [16];
   int checks = 0, errs = 0;

   always #5 clk = ~clk;

   sirv_axi_sram_slv #(.AW(32), .DW(64), .DEPTH(256)) dut (
      .clk(clk), .rst(rst),
      .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr), .axi_arcache(arcache),
      .axi_arprot(arprot), .axi_arlock(arlock), .axi_arburst(arburst), .axi_arlen(arlen),
      .axi_arsize(arsize),
      .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awcache(awcache),
      .axi_awprot(awprot), .axi_awlock(awlock), .axi_awburst(awburst), .axi_awlen(awlen),
      .axi_awsize(awsize),
      .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rresp(rresp),
      .axi_rlast(rlast),
      .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
      .axi_wlast(wlast),
      .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Word index of beat k: FIXED repeats the start word, other bursts step one word, modulo 256.
   function automatic int bidx(logic [31:0] a, int k, logic [1:0] b);
      return (int'(a[10:3]) + ((b == 2'b00) ? 0 : k)) % 256;
   endfunction

   task automatic send_ar(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b);
      int n = 0;
      arvalid = 1; araddr = a; arlen = l; arburst = b;
      arcache = 4'($urandom); arprot = 3'($urandom); arlock = 2'($urandom); arsize = 3'($urandom);
      #1;
      while (!arready && n < 60) begin @(negedge clk); #1; n++; end
      checks++;
      if (arready !== 1'b1) begin errs++; $display("FAIL ar_ready: got %b want 1", arready); end
      @(posedge clk);
      @(negedge clk);
      arvalid = 0;
   endtask

   task automatic send_aw(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b);
      int n = 0;
      awvalid = 1; awaddr = a; awlen = l; awburst = b;
      awcache = 4'($urandom); awprot = 3'($urandom); awlock = 2'($urandom); awsize = 3'($urandom);
      #1;
      while (!awready && n < 60) begin @(negedge clk); #1; n++; end
      checks++;
      if (awready !== 1'b1) begin errs++; $display("FAIL aw_ready: got %b want 1", awready); end
      @(posedge clk);
      @(negedge clk);
      awvalid = 0;
   endtask

   // Called at the first falling edge after the AR handshake.
   task automatic recv_r(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b, input int stall);
      logic [63:0] hd;
      logic hl;
      bit held;
      checks++;
      if (rvalid !== 1'b1) begin errs++; $display("FAIL first_rvalid: got %b want 1", rvalid); end
      for (int i = 0; i <= int'(l); i++) begin
         int n = 0;
         held = 0;
         forever begin
            rready = ($urandom_range(0, 99) >= stall);
            #1;
            if (held) begin
               checks++;
               if (rdata !== hd || rlast !== hl) begin
                  errs++; $display("FAIL r_stable: got %h/%b want %h/%b", rdata, rlast, hd, hl);
               end
            end
            if (rvalid && rready) break;
            if (++n > 60) begin
               checks++; errs++; $display("FAIL r_timeout: got rvalid %b want 1", rvalid);
               break;
            end
            hd = rdata; hl = rlast; held = 1;
            @(negedge clk);
         end
         if (b != 2'b11) begin
            checks++;
            if (rdata !== mem_m[bidx(a, i, b)]) begin
               errs++; $display("FAIL r_data beat %0d: got %h want %h", i, rdata, mem_m[bidx(a, i, b)]);
            end
         end
         checks++;
         if (rlast !== (i == int'(l))) begin errs++; $display("FAIL r_last beat %0d: got %b want %b", i, rlast, i == int'(l)); end
         checks++;
         if (rresp !== ((b == 2'b11) ? 2'b10 : 2'b00)) begin
            errs++; $display("FAIL r_resp beat %0d: got %b want %b", i, rresp, (b == 2'b11) ? 2'b10 : 2'b00);
         end
         checks++;
         if (awready !== 1'b0) begin errs++; $display("FAIL awready_in_rd: got %b want 0", awready); end
         @(negedge clk);
      end
      rready = 0;
      checks++;
      if (rvalid !== 1'b0) begin errs++; $display("FAIL r_done: got rvalid %b want 0", rvalid); end
   endtask

   task automatic read_burst(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b, input int stall);
      send_ar(a, l, b);
      recv_r(a, l, b, stall);
   endtask

   task automatic write_burst(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                              input int last_at, input int stall);
      logic [1:0] eb;
      int n;
      send_aw(a, l, b);
      for (int i = 0; i <= last_at; i++) begin
         wvalid = 0;
         while ($urandom_range(0, 99) < stall) @(negedge clk);
         wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
         #1;
         n = 0;
         while (!wready && n < 60) begin @(negedge clk); #1; n++; end
         checks++;
         if (wready !== 1'b1) begin errs++; $display("FAIL w_ready beat %0d: got %b want 1", i, wready); end
         if (b != 2'b11)
            for (int j = 0; j < 8; j++)
               if (ws[i][j]) mem_m[bidx(a, i, b)][8*j +: 8] = wd[i][8*j +: 8];
         @(negedge clk);
      end
      wvalid = 0; wlast = 0;
      eb = (b == 2'b11 || last_at != int'(l)) ? 2'b10 : 2'b00;
      n = 0;
      forever begin
         bready = ($urandom_range(0, 99) >= stall);
         #1;
         if (bvalid && bready) break;
         if (++n > 60) begin checks++; errs++; $display("FAIL b_timeout: got bvalid %b want 1", bvalid); break; end
         @(negedge clk);
      end
      checks++;
      if (bresp !== eb) begin errs++; $display("FAIL b_resp: got %b want %b", bresp, eb); end
      @(negedge clk);
      bready = 0;
      checks++;
      if (bvalid !== 1'b0) begin errs++; $display("FAIL b_done: got bvalid %b want 0", bvalid); end
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(negedge clk);
      checks += 9;
      if (rvalid !== 1'b0) begin errs++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
      if (bvalid !== 1'b0) begin errs++; $display("FAIL rst_bvalid: got %b want 0", bvalid); end
      if (wready !== 1'b0) begin errs++; $display("FAIL rst_wready: got %b want 0", wready); end
      if (rlast !== 1'b0) begin errs++; $display("FAIL rst_rlast: got %b want 0", rlast); end
      if (rresp !== 2'b00) begin errs++; $display("FAIL rst_rresp: got %b want 00", rresp); end
      if (bresp !== 2'b00) begin errs++; $display("FAIL rst_bresp: got %b want 00", bresp); end
      if (rdata !== 64'h0) begin errs++; $display("FAIL rst_rdata: got %h want 0", rdata); end
      if (arready !== 1'b0) begin errs++; $display("FAIL rst_arready: got %b want 0", arready); end
      if (awready !== 1'b0) begin errs++; $display("FAIL rst_awready: got %b want 0", awready); end
      rst = 0;
      #1;
      checks += 2;
      if (arready !== 1'b1) begin errs++; $display("FAIL idle_arready: got %b want 1", arready); end
      if (awready !== 1'b1) begin errs++; $display("FAIL idle_awready: got %b want 1", awready); end
      @(negedge clk);
   endtask

   task automatic test_fill;
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
         write_burst(32'(k * 128), 4'd15, 2'b01, 15, 10);
      end
   endtask

   task automatic test_incr;
      wd[0] = 64'h1111; wd[1] = 64'h2222; wd[2] = 64'h3333; wd[3] = 64'h4444;
      for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
      write_burst(32'h10, 4'd3, 2'b01, 3, 0);
      send_ar(32'h10, 4'd3, 2'b01);
      checks++;
      if (rdata !== 64'h1111) begin errs++; $display("FAIL incr_first: got %h want 1111", rdata); end
      recv_r(32'h10, 4'd3, 2'b01, 0);
   endtask

   task automatic test_strobe;
      wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
      write_burst(32'h0, 4'd0, 2'b01, 0, 0);
      wd[0] = 64'h0; ws[0] = 8'h0F;
      write_burst(32'h0, 4'd0, 2'b01, 0, 0);
      send_ar(32'h0, 4'd0, 2'b01);
      checks++;
      if (rdata !== 64'hFFFF_FFFF_0000_0000) begin
         errs++; $display("FAIL strobe: got %h want ffffffff00000000", rdata);
      end
      recv_r(32'h0, 4'd0, 2'b01, 0);
   endtask

   task automatic test_collision;
      arvalid = 1; araddr = 32'h200; arlen = 4'd2; arburst = 2'b01;
      awvalid = 1; awaddr = 32'h300; awlen = 4'd1; awburst = 2'b01;
      #1;
      checks += 2;
      if (arready !== 1'b1) begin errs++; $display("FAIL coll_arready: got %b want 1", arready); end
      if (awready !== 1'b0) begin errs++; $display("FAIL coll_awready: got %b want 0", awready); end
      @(posedge clk);
      @(negedge clk);
      arvalid = 0;
      recv_r(32'h200, 4'd2, 2'b01, 30);
      #1;
      checks++;
      if (awready !== 1'b1) begin errs++; $display("FAIL coll_aw_after: got %b want 1", awready); end
      wd[0] = {$urandom, $urandom}; wd[1] = {$urandom, $urandom}; ws[0] = 8'hFF; ws[1] = 8'hA5;
      write_burst(32'h300, 4'd1, 2'b01, 1, 0);
      read_burst(32'h300, 4'd1, 2'b01, 0);
   endtask

   task automatic test_backpressure;
      logic [63:0] d0;
      logic l0;
      send_ar(32'h400, 4'd1, 2'b01);
      rready = 0;
      d0 = rdata; l0 = rlast;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (rvalid !== 1'b1 || rdata !== d0 || rlast !== l0) begin
            errs++; $display("FAIL bp_hold: got %b/%h/%b want 1/%h/%b", rvalid, rdata, rlast, d0, l0);
         end
      end
      recv_r(32'h400, 4'd1, 2'b01, 0);
   endtask

   task automatic test_errors;
      for (int i = 0; i < 3; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      write_burst(32'h500, 4'd2, 2'b01, 1, 0);
      read_burst(32'h500, 4'd2, 2'b01, 0);
      read_burst(32'h500, 4'd0, 2'b11, 0);
      for (int i = 0; i < 3; i++) wd[i] = {$urandom, $urandom};
      write_burst(32'h500, 4'd2, 2'b11, 2, 0);
      read_burst(32'h500, 4'd2, 2'b01, 0);
   endtask

   task automatic test_reset_mid;
      send_ar(32'h40, 4'd3, 2'b01);
      rready = 1;
      #1;
      checks++;
      if (rdata !== mem_m[8]) begin errs++; $display("FAIL mid_beat0: got %h want %h", rdata, mem_m[8]); end
      @(negedge clk);
      rready = 0; rst = 1;
      @(negedge clk);
      checks += 4;
      if (rvalid !== 1'b0) begin errs++; $display("FAIL mid_rvalid: got %b want 0", rvalid); end
      if (rdata !== 64'h0) begin errs++; $display("FAIL mid_rdata: got %h want 0", rdata); end
      if (rlast !== 1'b0) begin errs++; $display("FAIL mid_rlast: got %b want 0", rlast); end
      if (arready !== 1'b0) begin errs++; $display("FAIL mid_arready: got %b want 0", arready); end
      rst = 0;
      #1;
      checks++;
      if (arready !== 1'b1) begin errs++; $display("FAIL mid_idle: got %b want 1", arready); end
      @(negedge clk);
      read_burst(32'h40, 4'd3, 2'b01, 20);
   endtask

   task automatic test_random;
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         logic [3:0] l;
         logic [1:0] b;
         int st;
         a = $urandom; l = 4'($urandom); b = 2'($urandom); st = $urandom_range(0, 40);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
            write_burst(a, l, b, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : int'(l), st);
         end else
            read_burst(a, l, b, st);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_fill();
      test_incr();
      test_strobe();
      test_collision();
      test_backpressure();
      test_errors();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end
endmodule
